bm_cg_eval: RTL and testbench

- Reader side of the Box-Muller cos/slope ROM interface.
- Accepts one phase word per transaction and drives the ROM address port with two sequential lookups: cos point, then sin point.
- Captures the registered ROM data, applies quadrant folding and linear interpolation, and returns signed cos/sin samples over a valid/ready handshake.
- Sits between the uniform-phase generator and the Box-Muller multiplier stage.

---
 rtl/bm_cg_eval.sv | 144 ++++++++++++++
 tb/tb_bm_cg_eval.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bm_cg_eval.sv
// Box-Muller cos/sin evaluator: reads the cos/slope ROM and returns folded, interpolated samples.
// Ports: clock, reset (async, active-high), in_valid/in_ready/in_phase (phase request),
//        rom_addr/rom_rdata (registered ROM port), out_valid/out_ready/cos_out/sin_out (result).
module bm_cg_eval #(
    parameter int PHASE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PHASE_W-1:0]  in_phase,
    output logic [6:0]          rom_addr,
    input  logic [30:0]         rom_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [19:0]  cos_out,
    output logic signed [19:0]  sin_out
);

    localparam int FRAC_W = PHASE_W - 9;
    localparam int FW1    = (FRAC_W > 0) ? FRAC_W : 1;
    localparam int PW     = 12 + FW1;
    localparam int UW     = PHASE_W - 1;

    // Quarter turn as a phase word and as a folded-magnitude word
    localparam logic [PHASE_W-1:0] QTR = {2'b01, {(PHASE_W-2){1'b0}}};
    localparam logic [UW-1:0]      HU  = {1'b1, {(PHASE_W-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_A,
        S_B,
        S_C,
        S_OUT
    } state_t;

    state_t               r_state;
    logic [PHASE_W-1:0]   r_phase;
    logic [6:0]           r_addr;
    logic                 r_valid;
    logic signed [19:0]   r_cos;
    logic signed [19:0]   r_sin;

    logic [PHASE_W-1:0]   w_ph;
    logic [1:0]           w_q;
    logic [PHASE_W-3:0]   w_r;
    logic [UW-1:0]        w_u;
    logic                 w_neg;
    logic                 w_zero;
    logic [6:0]           w_idx;
    logic [6:0]           w_addr;
    logic [FW1-1:0]       w_fr;
    logic [18:0]          w_c;
    logic [11:0]          w_s;
    logic [PW-1:0]        w_prod;
    logic [18:0]          w_corr;
    logic [18:0]          w_mag;
    logic [19:0]          w_mag20;
    logic [19:0]          w_res;

    // One fold unit shared by all states: the cos lookup uses the phase,
    // the sin lookup uses the phase a quarter turn back.
    always_comb begin
        w_ph = r_phase - QTR;
        unique case (r_state)
            S_IDLE:  w_ph = in_phase;
            S_B:     w_ph = r_phase;
            default: w_ph = r_phase - QTR;
        endcase
    end

    assign w_q    = w_ph[PHASE_W-1 -: 2];
    assign w_r    = w_ph[PHASE_W-3:0];
    assign w_neg  = w_q[1] ^ w_q[0];
    assign w_u    = w_q[0] ? (HU - {1'b0, w_r}) : {1'b0, w_r};
    // u can only reach H on an odd quadrant with r = 0
    assign w_zero = w_u[UW-1];
    assign w_idx  = w_u[PHASE_W-3:FRAC_W];
    assign w_addr = w_zero ? 7'd127 : w_idx;

    generate
        if (FRAC_W > 0) begin : g_fr
            assign w_fr = w_u[FW1-1:0];
        end else begin : g_nofr
            assign w_fr = '0;
        end
    endgenerate

    assign w_c     = rom_rdata[30:12];
    assign w_s     = rom_rdata[11:0];
    assign w_prod  = PW'(w_s) * PW'(w_fr);
    assign w_corr  = 19'(w_prod >> FRAC_W);
    assign w_mag   = w_zero ? 19'd0 : (w_c - w_corr);
    assign w_mag20 = {1'b0, w_mag};
    assign w_res   = w_neg ? (20'd0 - w_mag20) : w_mag20;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_cos   <= '0;
            r_sin   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_phase <= in_phase;
                        r_addr  <= w_addr;
                        r_state <= S_A;
                    end
                end
                S_A: begin
                    r_addr  <= w_addr;
                    r_state <= S_B;
                end
                S_B: begin
                    r_cos   <= w_res;
                    r_state <= S_C;
                end
                S_C: begin
                    r_sin   <= w_res;
                    r_valid <= 1'b1;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign rom_addr  = r_addr;
    assign out_valid = r_valid;
    assign cos_out   = r_cos;
    assign sin_out   = r_sin;

endmodule

// File: tb/tb_bm_cg_eval.sv
// Testbench for bm_cg_eval: directed vectors against a registered ROM model.
// Checks addresses, latency, folded/interpolated results, backpressure and mid-flight reset.
module tb_bm_cg_eval;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_phase;
    logic [6:0]         rom_addr;
    logic [30:0]        rom_rdata;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] cos_out;
    logic signed [19:0] sin_out;

    int n_chk = 0;
    int n_bad = 0;

    logic [18:0] rc[128];
    logic [11:0] rs[128];

    typedef struct {
        logic [15:0] ph;
        int          a0;
        int          a1;
        int          c;
        int          s;
    } vec_t;

    vec_t tv[9];

    always #5 clock = ~clock;

    always_ff @(posedge clock) rom_rdata <= {rc[rom_addr], rs[rom_addr]};

    bm_cg_eval #(.PHASE_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_phase  (in_phase),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run(input string nm, input logic [15:0] ph,
                       input int a0, input int a1, input int c, input int s);
        int lat;
        bit seen;
        chk({nm, "_rdy"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_phase = ph;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_phase = ~ph;
        chk({nm, "_busy"}, int'(in_ready), 0);
        chk({nm, "_acos"}, int'(rom_addr), a0);
        @(posedge clock); #1;
        chk({nm, "_asin"}, int'(rom_addr), a1);
        lat = 1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clock); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        chk({nm, "_lat"}, seen ? lat : -1, 3);
        chk({nm, "_ahold"}, int'(rom_addr), a1);
        chk({nm, "_cos"}, int'(cos_out), c);
        chk({nm, "_sin"}, int'(sin_out), s);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({nm, "_ovlo"}, int'(out_valid), 0);
        chk({nm, "_rdy2"}, int'(in_ready), 1);
        chk({nm, "_keep"}, int'(cos_out), c);
    endtask

    initial begin
        int c0;
        int lat;
        bit seen;

        for (int i = 0; i < 128; i++) begin
            rc[i] = 19'(262146 - 2000 * i);
            rs[i] = 12'(3 * i);
        end
        rc[0]   = 19'd262146;
        rs[0]   = 12'd20;
        rc[127] = 19'd3217;
        rs[127] = 12'd3216;

        tv[0] = '{16'h0000,   0, 127,  262146,       0};
        tv[1] = '{16'h4000, 127,   0,       0,  262146};
        tv[2] = '{16'h8000,   0, 127, -262146,       0};
        tv[3] = '{16'h0040,   0, 127,  262136,    1609};
        tv[4] = '{16'h8040,   0, 127, -262136,   -1609};
        tv[5] = '{16'hC000, 127,   0,       0, -262146};
        tv[6] = '{16'h0285,   5, 122,  252146,   17795};
        tv[7] = '{16'h6A3F,  43,  84, -176081,   94022};
        tv[8] = '{16'hFFFF,   0, 127,  262146,     -27};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_phase  = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rdy",  int'(in_ready), 1);
        chk("rst_ov",   int'(out_valid), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_cos",  int'(cos_out), 0);
        chk("rst_sin",  int'(sin_out), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++)
            run($sformatf("v%0d", i), tv[i].ph, tv[i].a0, tv[i].a1, tv[i].c, tv[i].s);

        // Backpressure: result held while a new request waits
        in_valid = 1'b1;
        in_phase = 16'h0040;
        @(posedge clock); #1;
        in_phase = 16'h8000;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_ov", int'(seen), 1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            chk($sformatf("bp_cos%0d", k), int'(cos_out), 262136);
            chk($sformatf("bp_sin%0d", k), int'(sin_out), 1609);
            chk($sformatf("bp_ov%0d", k), int'(out_valid), 1);
            chk($sformatf("bp_rdy%0d", k), int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp_hs_ov",   int'(out_valid), 0);
        chk("bp_hs_rdy",  int'(in_ready), 1);
        chk("bp_hs_addr", int'(rom_addr), 127);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("bp_acc_rdy",  int'(in_ready), 0);
        chk("bp_acc_addr", int'(rom_addr), 0);
        @(posedge clock); #1;
        chk("bp_asin", int'(rom_addr), 127);
        lat = 1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clock); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_lat", seen ? lat : -1, 3);
        chk("bp_cos", int'(cos_out), -262146);
        chk("bp_sin", int'(sin_out), 0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;

        // Reset while in state B
        c0 = int'(cos_out);
        chk("pre_rst_cos", c0, -262146);
        in_valid = 1'b1;
        in_phase = 16'h0285;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("mid_addr", int'(rom_addr), 122);
        reset = 1'b1;
        #1;
        chk("mr_ov",   int'(out_valid), 0);
        chk("mr_addr", int'(rom_addr), 0);
        chk("mr_rdy",  int'(in_ready), 1);
        chk("mr_cos",  int'(cos_out), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("mr_nores", int'(out_valid), 0);
        chk("mr_addr2", int'(rom_addr), 0);
        run("after_rst", 16'h6A3F, 43, 84, -176081, 94022);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
